j_dspbus: RTL and testbench
===========================

# j_dspbus

DSP external bus-master sequencer directly downstream of the DSP memory interface. It consumes the memory interface's active-low data request (`dreql`) and latched `rw` / `siz`, and obtains the system bus from the top-level arbiter. It runs one external memory cycle per request and returns `dtackl` and the `dbrl[1:0]` drive-release lines to the memory interface. It holds the bus briefly after each cycle so back-to-back DSP accesses skip re-arbitration.

## Interface
Parameters:
- `TIMEOUT`, default 255: DATA-phase cycles before a watchdog abort (only with the macro). Legal range 1..1023.
- `HOLD_CYCLES`, default 3: idle cycles the bus is retained after DONE. Legal range 0..15.

Ports:
- `sys_clk`  in  1: sole clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `dreql`  in  1: DSP data request, active low, from the memory interface.
- `rw`  in  1: 1 = read, 0 = write. Valid while `dreql` = 0.
- `siz`  in  2: transfer size. Latched with `rw`.
- `bgl`  in  1: bus grant from the system arbiter, active low.
- `ackl`  in  1: external cycle acknowledge, active low.
- `pri_reql`  in  1: higher-priority master wants the bus, active low.
- `breql`  out  1: bus request to the arbiter, active low.
- `dtackl`  out  1: cycle-complete strobe to the memory interface, active low.
- `dbrl`  out  2: bit0 low = address bus is owned; bit1 low = data bus is owned.
- `aen_x`  out  1: external address drive enable.
- `den_x`  out  1: external data drive enable (writes only).
- `siz_x`  out  2: latched size to the pads.
- `buserr`  out  1: watchdog abort pulse. Constant 0 without the macro.

## Operation
States: IDLE, REQ, ADDR, DATA, DONE, HOLD. All outputs are registered.

Reset (asynchronous) values: state IDLE, `breql`=1, `dtackl`=1, `dbrl`=2'b11, `aen_x`=0, `den_x`=0, `siz_x`=0, `buserr`=0, counters 0.

State behaviour:
- **IDLE:** if `dreql`=0, go to REQ and set `breql`=0.
- **REQ:** `breql`=0.
  - `bgl`=0: go to ADDR, latch `rw`/`siz`, set `dbrl[0]`=0.
  - `dreql` returns to 1 before grant (withdrawn): go to IDLE and set `breql`=1.
- **ADDR:** exactly one cycle. `aen_x`=1. Next state DATA. `dbrl[1]`=0 is set entering DATA.
- **DATA:** `aen_x`=1 and `den_x`=~rw_latched. `ackl`=0 → DONE. The watchdog counts here (see Configuration).
- **DONE:** one cycle. `dtackl`=0; `aen_x`/`den_x`=0; `dbrl`=2'b11. Next state HOLD with the hold counter loaded to `HOLD_CYCLES`. `breql` stays 0.
- **HOLD:** `dreql` is sampled here. The memory interface drops `dreql` in the cycle it sees `dtackl`=0, so any low seen in HOLD is a new request.
  - Priority order, highest first:
    1. `pri_reql`=0 or `bgl`=1 → IDLE.
    2. `dreql`=0 → ADDR, relatch `rw`/`siz`.
    3. Counter 0 → IDLE.
    4. Otherwise decrement the counter.
  - `breql` returns to 1 on entering IDLE.
  - `HOLD_CYCLES`=0: HOLD lasts one cycle.

Boundary rules:
- Loss of `bgl` or `pri_reql`=0 during ADDR/DATA does not abort the cycle; it is honoured at HOLD.
- `ackl` is ignored outside DATA.
- `reset` mid-cycle forces IDLE immediately. The memory interface must not expect `dtackl`.

## Timing
- Dreql sampled low at edge n: `breql` low after edge n.
- With `bgl` low at edge n+1: ADDR n+1, DATA n+2.
- Earliest `ackl` sample is at n+3, giving `dtackl` low for the cycle after edge n+3. Minimum latency is 4 cycles.
- Back-to-back request from HOLD sampled at edge m: `dtackl` low after edge m+2 (3 cycles).
- Each extra `ackl` wait state adds 1 cycle.
- `dtackl` is low for exactly one cycle per cycle run.

## Configuration
- `J_DSPBUS_WATCHDOG_EN` defined:
  - A counter of width $clog2(TIMEOUT+1) clears on ADDR and increments each DATA cycle.
  - On reaching `TIMEOUT` with `ackl`=1, the block enters DONE and `buserr`=1 for the same single cycle as `dtackl`=0.
  - `ackl`=0 on the TIMEOUT cycle counts as a normal ack; `buserr` stays 0.
- Undefined: DATA waits indefinitely; `buserr` is tied 0; no counter logic.

## Structure
- Package `j_dspbus_pkg`: state enum (6 states, one-hot encoding), `HOLD_W`=4, and `TIMEOUT` / `HOLD_CYCLES` default constants.
- One sub-module, `j_dspbus_wdog` (clear, count-enable, terminal-count output). Instantiated only under `J_DSPBUS_WATCHDOG_EN`.

## Test plan
- Read, grant immediate, `ackl` low on first DATA cycle:
  - `dtackl` low 4 cycles after the `dreql` sample.
  - `den_x`=0 throughout; `aen_x` high for 2 cycles.
- Write with `siz`=2, 2 `ackl` wait states:
  - `den_x` high for 3 DATA cycles; `siz_x`=2.
  - `dtackl` low at cycle 6; `dbrl` returns to 2'b11 in DONE.
- Back-to-back: second `dreql` low in the first HOLD cycle:
  - No `breql` deassertion; `dtackl` low 3 cycles later.
  - `HOLD_CYCLES`=3 with no further request → `breql` high after 4 HOLD cycles.
- Request withdrawn in REQ (`bgl` held high 5 cycles, then `dreql`=1): IDLE and `breql`=1 next cycle, no `dtackl`.
- `pri_reql`=0 asserted mid-DATA:
  - The cycle completes normally.
  - HOLD exits to IDLE after one cycle; `breql`=1.
- With macro, `TIMEOUT`=8 and `ackl` never low: `buserr` and `dtackl` low together after 8 DATA cycles. Async `reset` mid-DATA → all outputs at reset values immediately.

Source files
------------

// File: rtl/j_dspbus_pkg.sv
// j_dspbus_pkg: shared state encoding and default constants for the DSP bus sequencer
package j_dspbus_pkg;
  localparam int HOLD_W = 4;
  localparam int TIMEOUT_DEF = 255;
  localparam int HOLD_CYCLES_DEF = 3;
  typedef enum logic [5:0] {
    IDLE = 6'b000001,
    REQ  = 6'b000010,
    ADDR = 6'b000100,
    DATA = 6'b001000,
    DONE = 6'b010000,
    HOLD = 6'b100000
  } state_t;
endpackage

// File: rtl/j_dspbus_wdog.sv
// j_dspbus_wdog: DATA-phase watchdog, flags the TIMEOUT-th counted cycle
module j_dspbus_wdog #(
  parameter int TIMEOUT = 255,
  parameter int W = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [W-1:0] cnt;
  // count DATA cycles since the last ADDR
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign tc = en && (cnt == W'(TIMEOUT - 1));
endmodule

// File: rtl/j_dspbus.sv
// j_dspbus: external bus-master sequencer for DSP memory requests (watchdog via J_DSPBUS_WATCHDOG_EN)
module j_dspbus
  import j_dspbus_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       dreql,
  input  logic       rw,
  input  logic [1:0] siz,
  input  logic       bgl,
  input  logic       ackl,
  input  logic       pri_reql,
  output logic       breql,
  output logic       dtackl,
  output logic [1:0] dbrl,
  output logic       aen_x,
  output logic       den_x,
  output logic [1:0] siz_x,
  output logic       buserr
);
  state_t state, nxt;
  logic [HOLD_W-1:0] hcnt, hcnt_n;
  logic rw_l, rw_n;
  logic [1:0] siz_n;
  logic to;
`ifdef J_DSPBUS_WATCHDOG_EN
  logic tc;
  j_dspbus_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk(sys_clk),
    .rst(reset),
    .clr(state == ADDR),
    .en(state == DATA),
    .tc(tc)
  );
  assign to = tc & ackl;
`else
  assign to = 1'b0;
`endif
  // next state, hold counter and relatched transfer attributes
  always_comb begin
    nxt = state;
    hcnt_n = hcnt;
    rw_n = rw_l;
    siz_n = siz_x;
    case (state)
      IDLE: nxt = dreql ? IDLE : REQ;
      REQ:
        if (!bgl) begin
          nxt = ADDR;
          rw_n = rw;
          siz_n = siz;
        end else if (dreql) nxt = IDLE;
      ADDR: nxt = DATA;
      DATA: nxt = (!ackl || to) ? DONE : DATA;
      DONE: begin
        nxt = HOLD;
        hcnt_n = HOLD_W'(HOLD_CYCLES);
      end
      HOLD:
        if (!pri_reql || bgl) nxt = IDLE;
        else if (!dreql) begin
          nxt = ADDR;
          rw_n = rw;
          siz_n = siz;
        end else if (hcnt == '0) nxt = IDLE;
        else hcnt_n = hcnt - 1'b1;
      default: nxt = IDLE;
    endcase
  end
  // state plus outputs registered from the state being entered
  always_ff @(posedge sys_clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      hcnt <= '0;
      rw_l <= 1'b0;
      siz_x <= 2'b00;
      breql <= 1'b1;
      dtackl <= 1'b1;
      dbrl <= 2'b11;
      aen_x <= 1'b0;
      den_x <= 1'b0;
      buserr <= 1'b0;
    end else begin
      state <= nxt;
      hcnt <= hcnt_n;
      rw_l <= rw_n;
      siz_x <= siz_n;
      breql <= nxt == IDLE;
      dtackl <= nxt != DONE;
      dbrl <= (nxt == ADDR) ? 2'b10 : (nxt == DATA) ? 2'b00 : 2'b11;
      aen_x <= (nxt == ADDR) || (nxt == DATA);
      den_x <= (nxt == DATA) && !rw_n;
      buserr <= (state == DATA) && to;
    end
endmodule

// File: tb/tb_j_dspbus.sv
// tb_j_dspbus: table-driven and randomized transaction checks for j_dspbus
module tb_j_dspbus;
  localparam int H = 3;
  logic sys_clk = 0, reset = 1, dreql = 1, rw = 0, bgl = 1, ackl = 1, pri_reql = 1;
  logic [1:0] siz = 0;
  logic breql, dtackl, aen_x, den_x, buserr;
  logic [1:0] dbrl, siz_x;
  int n_chk = 0, n_pass = 0;

  typedef struct {
    bit rw; bit [1:0] siz; int g; int w; bit b2b; int k; int hx; int lat;
  } vec_t;
  vec_t tab[$];

  j_dspbus #(.TIMEOUT(8), .HOLD_CYCLES(H)) dut (
    .sys_clk(sys_clk), .reset(reset), .dreql(dreql), .rw(rw), .siz(siz), .bgl(bgl),
    .ackl(ackl), .pri_reql(pri_reql), .breql(breql), .dtackl(dtackl), .dbrl(dbrl),
    .aen_x(aen_x), .den_x(den_x), .siz_x(siz_x), .buserr(buserr)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk_idle_outs(input string nm);
    chk({nm, "_breql"}, breql, 1);
    chk({nm, "_dtackl"}, dtackl, 1);
    chk({nm, "_dbrl"}, dbrl, 3);
    chk({nm, "_aen"}, aen_x, 0);
    chk({nm, "_den"}, den_x, 0);
    chk({nm, "_buserr"}, buserr, 0);
  endtask

  task automatic run_txn(input vec_t v);
    int e;
    if (v.b2b) begin
      for (int i = 0; i <= v.k; i++) begin
        step();
        chk("hold_breql", breql, 0);
        chk("hold_dtackl", dtackl, 1);
      end
      dreql = 0; rw = v.rw; siz = v.siz;
      step(); e = 1;
    end else begin
      dreql = 0; rw = v.rw; siz = v.siz; bgl = 1;
      step(); e = 1;
      chk("req_breql", breql, 0);
      chk("req_aen", aen_x, 0);
      for (int i = 0; i < v.g; i++) begin
        step(); e++;
        chk("wait_breql", breql, 0);
        chk("wait_dbrl", dbrl, 3);
      end
      bgl = 0;
      step(); e++;
    end
    chk("addr_aen", aen_x, 1);
    chk("addr_den", den_x, 0);
    chk("addr_dbrl", dbrl, 2);
    chk("addr_siz", siz_x, v.siz);
    chk("addr_dtackl", dtackl, 1);
    rw = ~v.rw; siz = ~v.siz;
    ackl = 1'($urandom_range(0, 1));
    step(); e++;
    for (int j = 0; j <= v.w; j++) begin
      chk("data_aen", aen_x, 1);
      chk("data_den", den_x, !v.rw);
      chk("data_dbrl", dbrl, 0);
      chk("data_dtackl", dtackl, 1);
      ackl = (j == v.w) ? 1'b0 : 1'b1;
      if (v.hx == 1) pri_reql = 0;
      if (v.hx == 2) bgl = 1;
      step(); e++;
    end
    chk("done_dtackl", dtackl, 0);
    chk("done_aen", aen_x, 0);
    chk("done_den", den_x, 0);
    chk("done_dbrl", dbrl, 3);
    chk("done_breql", breql, 0);
    chk("done_buserr", buserr, 0);
    chk("done_siz", siz_x, v.siz);
    chk("latency", e, v.lat);
    dreql = 1; ackl = 1;
  endtask

  task automatic hold_tail(input int hx);
    if (hx != 0) begin
      step();
      chk("hx_hold_breql", breql, 0);
      step();
      chk_idle_outs("hx_idle");
    end else begin
      for (int i = 0; i <= H; i++) begin
        step();
        chk("tail_breql", breql, 0);
        chk("tail_dtackl", dtackl, 1);
      end
      step();
      chk_idle_outs("tail_idle");
    end
    pri_reql = 1; bgl = 1;
  endtask

  initial begin
    tab.push_back('{1, 0, 0, 0, 0, 0, 0, 4});
    tab.push_back('{0, 2, 0, 2, 0, 0, 0, 6});
    tab.push_back('{1, 1, 2, 1, 0, 0, 0, 7});
    tab.push_back('{0, 3, 0, 0, 1, 0, 0, 3});
    tab.push_back('{1, 0, 1, 2, 0, 0, 1, 7});
    tab.push_back('{0, 1, 0, 1, 0, 0, 2, 5});
    tab.push_back('{1, 2, 0, 7, 0, 0, 0, 11});
    tab.push_back('{0, 1, 0, 0, 1, 3, 0, 3});
    for (int i = 0; i < 24; i++) begin
      vec_t v;
      v.rw = 1'($urandom_range(0, 1));
      v.siz = 2'($urandom_range(0, 3));
      v.g = $urandom_range(0, 3);
      v.w = $urandom_range(0, 5);
      v.b2b = (tab[tab.size() - 1].hx == 0) && ($urandom_range(0, 1) == 1);
      v.k = $urandom_range(0, H);
      v.hx = $urandom_range(0, 2);
      v.lat = v.b2b ? 3 + v.w : 4 + v.g + v.w;
      tab.push_back(v);
    end

    #12;
    chk_idle_outs("rst");
    chk("rst_siz", siz_x, 0);
    reset = 0;
    step();
    chk_idle_outs("post_rst");

    for (int i = 0; i < tab.size(); i++) begin
      run_txn(tab[i]);
      if (i + 1 == tab.size() || !tab[i + 1].b2b) hold_tail(tab[i].hx);
    end

    dreql = 0; bgl = 1;
    step();
    chk("wd_req_breql", breql, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("wd_wait_breql", breql, 0);
    end
    dreql = 1;
    step();
    chk_idle_outs("withdraw");
    step();
    chk("withdraw_dtackl", dtackl, 1);

`ifdef J_DSPBUS_WATCHDOG_EN
    dreql = 0; rw = 0; siz = 1; bgl = 1;
    step();
    bgl = 0;
    step();
    step();
    for (int d = 1; d <= 8; d++) begin
      step();
      if (d < 8) begin
        chk("to_data_den", den_x, 1);
        chk("to_data_buserr", buserr, 0);
      end else begin
        chk("to_dtackl", dtackl, 0);
        chk("to_buserr", buserr, 1);
      end
    end
    dreql = 1;
    step();
    chk("to_buserr_single", buserr, 0);
    chk("to_dtackl_single", dtackl, 1);
    bgl = 1;
    step();
    chk("to_idle_breql", breql, 1);
`endif

    dreql = 0; rw = 0; siz = 3; bgl = 1;
    step();
    bgl = 0;
    step();
    step();
    chk("pre_rst_den", den_x, 1);
    #3 reset = 1;
    #1;
    chk_idle_outs("async_rst");
    chk("async_rst_siz", siz_x, 0);
    dreql = 1; bgl = 1;
    step();
    reset = 0;
    step();
    chk_idle_outs("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
